// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Used by fifo_wr_arbiter and rr_pick.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_BURST_MAX  = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int b);
        return $clog2(b + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req scanning
// upward from start with wrap-around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_w(DEF_NUM_REQ)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded scheduler for the FIFO write port.
// Define FIFO_WR_ARBITER_PRIO_EN to give requester 0 priority.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk_a,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wen_a,
    output logic [DATA_WIDTH-1:0]         din_a,
    output logic [idx_w(NUM_REQ)-1:0]     owner,
    output logic                          busy
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = cnt_w(BURST_MAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    state_t        state, state_n;
    logic [IW-1:0] owner_n;
    logic [IW-1:0] last, last_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          wr;
    logic          rel;
    logic [IW-1:0] base;
    logic [IW-1:0] start;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] sel_idx;

    // Owner's own request ranks last after a release.
    assign base  = (state == OWN) ? owner : last;
    assign start = (base == LAST_IDX) ? '0 : base + IW'(1);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .start (start),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

`ifdef FIFO_WR_ARBITER_PRIO_EN
    assign sel_idx = req[0] ? '0 : pick_idx;
`else
    assign sel_idx = pick_idx;
`endif

    assign wr    = (state == OWN) && req[owner] && !full;
    assign rel   = !req[owner] || (wr && cnt == CW'(BURST_MAX - 1));
    assign wen_a = wr;
    assign busy  = (state == OWN);
    assign din_a = wr ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH]
                      : '0;

    always_comb begin
        gnt        = '0;
        gnt[owner] = wr;
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_n = sel_idx;
                    cnt_n   = '0;
                    state_n = OWN;
                end
            end
            OWN: begin
                if (rel) begin
                    last_n = owner;
                    if (pick_vld) begin
                        owner_n = sel_idx;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (wr) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last  <= LAST_IDX;
            cnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 req, 16b, burst 4).
// Expectation for the priority case follows FIFO_WR_ARBITER_PRIO_EN.
module tb_fifo_wr_arbiter;

    logic        clk_a = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic        full;
    logic [3:0]  gnt;
    logic        wen_a;
    logic [15:0] din_a;
    logic [1:0]  owner;
    logic        busy;

    logic [15:0] word [4];
    int          errors = 0;
    int          checks = 0;

    assign req_data = {word[3], word[2], word[1], word[0]};

    always #5 clk_a = ~clk_a;

    fifo_wr_arbiter dut (
        .clk_a    (clk_a),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .wen_a    (wen_a),
        .din_a    (din_a),
        .owner    (owner),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Producers advance their word after each grant.
    task automatic tick();
        logic [3:0] g;
        #1;
        g = gnt;
        @(posedge clk_a);
        #2;
        for (int i = 0; i < 4; i++)
            if (g[i]) word[i] = word[i] + 16'd1;
    endtask

    task automatic do_reset();
        req  = '0;
        full = 1'b0;
        rst  = 1'b1;
        #3;
        rst  = 1'b0;
        #1;
    endtask

    int sent [4];
    int expo;
    int occ;
    int total;
    int viol;
    int seqn [4];
    logic rd;

    initial begin
        rst  = 1'b1;
        req  = '0;
        full = 1'b0;
        for (int i = 0; i < 4; i++) word[i] = '0;
        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wen", 32'(wen_a), 0);
        chk("rst_din", 32'(din_a), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        rst = 1'b0;
        @(posedge clk_a);
        #2;

        // single requester
        word[2] = 16'hA000;
        req = 4'b0100;
        #1;
        chk("t1_arb_wen", 32'(wen_a), 0);
        chk("t1_arb_busy", 32'(busy), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t1_wen", 32'(wen_a), 1);
            chk("t1_gnt", 32'(gnt), 32'h4);
            chk("t1_owner", 32'(owner), 2);
            chk("t1_din", 32'(din_a), 32'hA000 + k);
            tick();
        end
        req = 4'b0000;
        #1;
        chk("t1_drop_wen", 32'(wen_a), 0);
        tick();
        chk("t1_idle_busy", 32'(busy), 0);

        // all four, round robin
        do_reset();
        for (int i = 0; i < 4; i++) begin
            word[i] = 16'(i << 12);
            sent[i] = 0;
        end
        req = 4'hF;
        #1;
        chk("t2_arb_wen", 32'(wen_a), 0);
        tick();
        for (int k = 0; k < 17; k++) begin
            expo = (k / 4) % 4;
            #1;
            chk("t2_wen", 32'(wen_a), 1);
            chk("t2_owner", 32'(owner), 32'(expo));
            chk("t2_din", 32'(din_a), 32'((expo << 12) + sent[expo]));
            sent[expo]++;
            tick();
        end

        // full stall
        do_reset();
        word[1] = 16'h1000;
        req = 4'b0010;
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_wen_pre", 32'(wen_a), 1);
            chk("t3_din_pre", 32'(din_a), 32'h1000 + k);
            tick();
        end
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_stall_wen", 32'(wen_a), 0);
            chk("t3_stall_gnt", 32'(gnt), 0);
            chk("t3_stall_owner", 32'(owner), 1);
            tick();
        end
        full = 1'b0;
        for (int k = 2; k < 4; k++) begin
            #1;
            chk("t3_wen_post", 32'(wen_a), 1);
            chk("t3_din_post", 32'(din_a), 32'h1000 + k);
            tick();
        end
        #1;
        chk("t3_regrant", 32'(gnt), 32'h2);
        req = '0;
        tick();

        // reset mid-burst
        do_reset();
        req = 4'hF;
        tick();
        for (int k = 0; k < 13; k++) tick();
        #1;
        chk("t4_o3_wen", 32'(wen_a), 1);
        chk("t4_o3_owner", 32'(owner), 3);
        rst = 1'b1;
        #1;
        chk("t4_rst_wen", 32'(wen_a), 0);
        chk("t4_rst_gnt", 32'(gnt), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        #1;
        rst = 1'b0;
        #1;
        chk("t4_arb_wen", 32'(wen_a), 0);
        tick();
        #1;
        chk("t4_first_gnt", 32'(gnt), 32'h1);

        // priority vs round robin
        do_reset();
        req = 4'b1001;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_o0", 32'(owner), 0);
            tick();
        end
`ifdef FIFO_WR_ARBITER_PRIO_EN
        chk("t5_next", 32'(owner), 0);
`else
        chk("t5_next", 32'(owner), 3);
`endif

        // system: 4 x 8 tagged words into a depth-16 FIFO model
        do_reset();
        for (int i = 0; i < 4; i++) begin
            word[i] = 16'(i << 12);
            seqn[i] = 0;
        end
        req   = 4'hF;
        occ   = 0;
        total = 0;
        viol  = 0;
        for (int c = 0; c < 2000 && total < 32; c++) begin
            full = (occ == 16);
            #1;
            rd = 1'($urandom_range(0, 1));
            if (rd && occ > 0) occ--;
            if (wen_a) begin
                if (full) viol++;
                chk("t6_word", 32'(din_a),
                    32'((int'(owner) << 12) + seqn[owner]));
                seqn[owner]++;
                total++;
                occ++;
            end
            tick();
            for (int i = 0; i < 4; i++)
                req[i] = (word[i][11:0] < 12'd8);
        end
        chk("t6_total", 32'(total), 32);
        chk("t6_full_viol", 32'(viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
